// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the DAC command scheduler
package dac_pkg;

  localparam int FRAME_W  = 24;
  localparam int SAMPLE_W = 16;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] DAC_ADDR_A       = 4'h0;
  localparam logic [3:0] DAC_ADDR_B       = 4'h1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_t;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [3:0]          cmd,
    input logic [3:0]          addr,
    input logic [SAMPLE_W-1:0] sample
  );
    return {cmd, addr, sample};
  endfunction

endpackage

// File: rtl/dac_channel_latch.sv
// rtl/dac_channel_latch.sv - per-channel sample holding register with pending and overrun flags
module dac_channel_latch
  import dac_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                valid_i,
  input  logic                grant_clr_i,
  input  logic                ovr_clr_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                pending_o,
  output logic                overrun_o
);

  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                ovr_event;

  // A strobe landing on the grant cycle refills the slot rather than losing a sample.
  assign ovr_event = valid_i && pending_q && !grant_clr_i;

  always_comb begin
    sample_d  = sample_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (valid_i) begin
      sample_d  = sample_i;
      pending_d = 1'b1;
    end else if (grant_clr_i) begin
      pending_d = 1'b0;
    end
    if (ovr_event) begin
      overrun_d = 1'b1;
    end else if (ovr_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q  <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_o  = sample_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/dac_scheduler.sv
// rtl/dac_scheduler.sv - sends the init word, then arbitrates channel A/B samples into
// DAC write frames for the SPI serializer with retry and inter-frame gap.
module dac_scheduler
  import dac_pkg::*;
#(
  parameter logic [FRAME_W-1:0] INIT_WORD   = 24'h380001,
  parameter logic [3:0]         CMD_WRITE   = CMD_WRITE_UPDATE,
  parameter logic [3:0]         ADDR_A      = DAC_ADDR_A,
  parameter logic [3:0]         ADDR_B      = DAC_ADDR_B,
  parameter int                 GAP_CYCLES  = 24,
  parameter int                 ACK_TIMEOUT = 8
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_a,
  input  logic                sample_a_valid,
  input  logic [SAMPLE_W-1:0] sample_b,
  input  logic                sample_b_valid,
  input  logic                dac_cs,
  output logic                dac_send,
  output logic [FRAME_W-1:0]  dac_data,
  output logic                busy,
  output logic                init_done,
  output logic [1:0]          overrun,
  input  logic                overrun_clr
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t               state_q, state_d;
  chan_t                last_grant_q, last_grant_d;
  logic                 send_q, send_d;
  logic [FRAME_W-1:0]   data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 init_done_q, init_done_d;
  logic                 init_frame_q, init_frame_d;
  logic                 fire_q, fire_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [GW-1:0]        gap_q, gap_d;

  logic                 grant_a, grant_b;
  logic [SAMPLE_W-1:0]  held_a, held_b;
  logic                 pend_a, pend_b;
  logic                 ovr_a, ovr_b;

  dac_channel_latch u_latch_a (
    .clk_i       (clock_in),
    .rst_ni      (reset_n),
    .sample_i    (sample_a),
    .valid_i     (sample_a_valid),
    .grant_clr_i (grant_a),
    .ovr_clr_i   (overrun_clr),
    .sample_o    (held_a),
    .pending_o   (pend_a),
    .overrun_o   (ovr_a)
  );

  dac_channel_latch u_latch_b (
    .clk_i       (clock_in),
    .rst_ni      (reset_n),
    .sample_i    (sample_b),
    .valid_i     (sample_b_valid),
    .grant_clr_i (grant_b),
    .ovr_clr_i   (overrun_clr),
    .sample_o    (held_b),
    .pending_o   (pend_b),
    .overrun_o   (ovr_b)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    send_d       = 1'b0;
    data_d       = data_q;
    init_done_d  = init_done_q;
    init_frame_d = init_frame_q;
    fire_d       = 1'b0;
    timer_d      = timer_q;
    gap_d        = gap_q;
    grant_a      = 1'b0;
    grant_b      = 1'b0;

    case (state_q)
      ST_INIT: begin
        data_d       = INIT_WORD;
        send_d       = 1'b1;
        timer_d      = '0;
        init_frame_d = 1'b1;
        state_d      = ST_WAIT_ACK;
      end

      ST_IDLE: begin
        if (pend_a || pend_b) begin
          if (pend_a && (!pend_b || last_grant_q == CH_B)) begin
            grant_a      = 1'b1;
            last_grant_d = CH_A;
            data_d       = make_frame(CMD_WRITE, ADDR_A, held_a);
          end else begin
            grant_b      = 1'b1;
            last_grant_d = CH_B;
            data_d       = make_frame(CMD_WRITE, ADDR_B, held_b);
          end
          // Data settles this cycle; the send pulse follows from WAIT_ACK.
          fire_d       = 1'b1;
          timer_d      = '0;
          init_frame_d = 1'b0;
          state_d      = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        if (fire_q) begin
          send_d  = 1'b1;
          timer_d = '0;
        end else if (!dac_cs) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          send_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (dac_cs) begin
          gap_d   = GW'(GAP_CYCLES);
          state_d = ST_GAP;
          if (init_frame_q) begin
            init_done_d = 1'b1;
          end
        end
      end

      ST_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      last_grant_q <= CH_B;
      send_q       <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b1;
      init_done_q  <= 1'b0;
      init_frame_q <= 1'b0;
      fire_q       <= 1'b0;
      timer_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      send_q       <= send_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      init_done_q  <= init_done_d;
      init_frame_q <= init_frame_d;
      fire_q       <= fire_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
    end
  end

  assign dac_send  = send_q;
  assign dac_data  = data_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign overrun   = {ovr_b, ovr_a};

endmodule

// File: tb/tb_dac_scheduler.sv
// tb/tb_dac_scheduler.sv - scoreboard bench for dac_scheduler with a simple serializer model
module tb_dac_scheduler;

  localparam int FRAME_LEN = 12;

  logic        clock_in = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_a = '0;
  logic        sample_a_valid = 1'b0;
  logic [15:0] sample_b = '0;
  logic        sample_b_valid = 1'b0;
  logic        dac_cs = 1'b1;
  logic        overrun_clr = 1'b0;
  logic        dac_send;
  logic [23:0] dac_data;
  logic        busy;
  logic        init_done;
  logic [1:0]  overrun;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  bit          ser_block = 1'b0;

  dac_scheduler dut (
    .clock_in       (clock_in),
    .reset_n        (reset_n),
    .sample_a       (sample_a),
    .sample_a_valid (sample_a_valid),
    .sample_b       (sample_b),
    .sample_b_valid (sample_b_valid),
    .dac_cs         (dac_cs),
    .dac_send       (dac_send),
    .dac_data       (dac_data),
    .busy           (busy),
    .init_done      (init_done),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serializer stand-in: CS low for FRAME_LEN cycles per accepted send, aborted by reset.
  always begin
    @(negedge clock_in);
    if (reset_n && !ser_block && dac_send && dac_cs) begin
      dac_cs = 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        @(negedge clock_in);
        if (!reset_n) break;
      end
      dac_cs = 1'b1;
    end
  end

  logic [23:0] last_word = '0;
  bit          awaiting = 1'b0;
  bit          prev_send = 1'b0;

  always @(posedge clock_in) begin
    #1;
    if (!reset_n) begin
      awaiting  = 1'b0;
      prev_send = 1'b0;
    end else begin
      if (dac_send) begin
        chk("send_not_back_to_back", {31'd0, prev_send}, 32'd0);
        if (!awaiting) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_send: got %h expected none", dac_data);
          end else begin
            chk("frame_word", {8'd0, dac_data}, {8'd0, exp_q.pop_front()});
          end
          last_word = dac_data;
          awaiting  = 1'b1;
        end else begin
          chk("retry_word", {8'd0, dac_data}, {8'd0, last_word});
        end
      end
      if (!dac_cs) awaiting = 1'b0;
      prev_send = dac_send;
    end
  end

  task automatic step();
    @(negedge clock_in);
    #1;
  endtask

  task automatic wait_cs(input logic level, input int max, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      step();
      if (dac_cs == level) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: cs never reached %0b within %0d cycles", name, level, max);
    end
  endtask

  task automatic wait_quiet(input string name);
    int idle_run = 0;
    for (int i = 0; i < 400 && idle_run < 3; i++) begin
      step();
      if (!busy) idle_run++;
      else idle_run = 0;
    end
    if (idle_run < 3) begin
      checks++;
      errors++;
      $display("FAIL %s: busy never settled low", name);
    end
  endtask

  task automatic strobe(input bit va, input logic [15:0] a, input bit vb, input logic [15:0] b);
    step();
    sample_a = a;
    sample_b = b;
    sample_a_valid = va;
    sample_b_valid = vb;
    step();
    sample_a_valid = 1'b0;
    sample_b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got_send;

    step();
    chk("rst_send", {31'd0, dac_send}, 32'd0);
    chk("rst_data", {8'd0, dac_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_overrun", {30'd0, overrun}, 32'd0);

    // Init frame, with a sample pair captured while it is in flight.
    exp_q.push_back(24'h380001);
    exp_q.push_back(24'h300777);
    exp_q.push_back(24'h310888);
    reset_n = 1'b1;
    strobe(1'b1, 16'h0777, 1'b1, 16'h0888);
    wait_cs(1'b0, 10, "init_cs_low");
    wait_cs(1'b1, 30, "init_cs_high");
    chk("init_done_before", {31'd0, init_done}, 32'd0);
    step();
    chk("init_done_after", {31'd0, init_done}, 32'd1);
    wait_quiet("init_quiet");

    // Simultaneous pairs alternate back to A first.
    exp_q.push_back(24'h30AAAA);
    exp_q.push_back(24'h315555);
    strobe(1'b1, 16'hAAAA, 1'b1, 16'h5555);
    wait_quiet("pair1_quiet");
    exp_q.push_back(24'h301111);
    exp_q.push_back(24'h312222);
    strobe(1'b1, 16'h1111, 1'b1, 16'h2222);
    wait_quiet("pair2_quiet");

    // Single sample latency and gap length.
    exp_q.push_back(24'h301234);
    step();
    sample_a = 16'h1234;
    sample_a_valid = 1'b1;
    step();
    sample_a_valid = 1'b0;
    chk("lat_c1_send", {31'd0, dac_send}, 32'd0);
    step();
    chk("lat_c2_send", {31'd0, dac_send}, 32'd0);
    step();
    chk("lat_c3_send", {31'd0, dac_send}, 32'd1);
    chk("lat_c3_data", {8'd0, dac_data}, 32'h00301234);
    wait_cs(1'b0, 5, "single_cs_low");
    wait_cs(1'b1, 30, "single_cs_high");
    chk("gap_busy_at_rise", {31'd0, busy}, 32'd1);
    repeat (24) step();
    chk("gap_busy_last", {31'd0, busy}, 32'd1);
    step();
    chk("gap_busy_released", {31'd0, busy}, 32'd0);
    wait_quiet("single_quiet");

    // Overrun: three A strobes during a B frame, clear on the last loses to the set.
    exp_q.push_back(24'h310BBB);
    exp_q.push_back(24'h300003);
    strobe(1'b0, 16'h0000, 1'b1, 16'h0BBB);
    wait_cs(1'b0, 10, "ovr_cs_low");
    step();
    sample_a = 16'h0001;
    sample_a_valid = 1'b1;
    step();
    sample_a = 16'h0002;
    step();
    sample_a = 16'h0003;
    overrun_clr = 1'b1;
    step();
    sample_a_valid = 1'b0;
    overrun_clr = 1'b0;
    chk("ovr_set_beats_clr", {30'd0, overrun}, 32'd1);
    wait_quiet("ovr_quiet");
    chk("ovr_sticky", {30'd0, overrun}, 32'd1);
    step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr_cleared", {30'd0, overrun}, 32'd0);

    // Strobe on the grant cycle keeps the slot pending without overrun.
    exp_q.push_back(24'h3000C1);
    exp_q.push_back(24'h3000C2);
    step();
    sample_a = 16'h00C1;
    sample_a_valid = 1'b1;
    step();
    sample_a = 16'h00C2;
    step();
    sample_a_valid = 1'b0;
    wait_quiet("grant_edge_quiet");
    chk("grant_edge_no_ovr", {30'd0, overrun}, 32'd0);

    // CS held high: send re-pulses every 8 cycles with identical data.
    ser_block = 1'b1;
    exp_q.push_back(24'h300055);
    strobe(1'b1, 16'h0055, 1'b0, 16'h0000);
    got_send = 1'b0;
    for (int i = 0; i < 10 && !got_send; i++) begin
      if (dac_send) got_send = 1'b1;
      else step();
    end
    chk("retry_first_send", {31'd0, got_send}, 32'd1);
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k < 8; k++) begin
        step();
        chk("retry_quiet_cycle", {31'd0, dac_send}, 32'd0);
      end
      step();
      chk("retry_repulse", {31'd0, dac_send}, 32'd1);
      chk("retry_data", {8'd0, dac_data}, 32'h00300055);
    end
    ser_block = 1'b0;
    wait_cs(1'b0, 20, "retry_cs_low");
    wait_cs(1'b1, 30, "retry_cs_high");
    wait_quiet("retry_quiet");

    // Reset during WAIT_DONE restarts with the init word.
    exp_q.push_back(24'h300066);
    strobe(1'b1, 16'h0066, 1'b0, 16'h0000);
    wait_cs(1'b0, 10, "mid_cs_low");
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_send", {31'd0, dac_send}, 32'd0);
    chk("mid_rst_data", {8'd0, dac_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    exp_q.push_back(24'h380001);
    repeat (3) step();
    reset_n = 1'b1;
    wait_cs(1'b0, 10, "reinit_cs_low");
    wait_cs(1'b1, 30, "reinit_cs_high");
    step();
    chk("reinit_done", {31'd0, init_done}, 32'd1);
    wait_quiet("reinit_quiet");
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
